fetch_sequencer: RTL and testbench



---
 rtl/fetch_sequencer_pkg.sv | 37 +++
 rtl/fetch_mode_decode.sv | 73 +++++++
 rtl/fetch_sequencer.sv | 193 +++++++++++++++++++
 tb/tb_fetch_sequencer.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_sequencer_pkg.sv
// Shared types for the 6502 fetch sequencer: FSM states, addressing-mode codes
// and the decoded-mode payload handed from the mode decoder to the sequencer.
package fetch_sequencer_pkg;

  localparam int unsigned OPC_W       = 8;
  localparam int unsigned MEM_LATENCY = 1;

  typedef enum logic [2:0] {
    FS_FETCH,
    FS_OP_CAP,
    FS_OPR_REQ,
    FS_OPR_CAP,
    FS_PTR_REQ,
    FS_PTR_CAP,
    FS_EXEC,
    FS_HALT
  } fs_state_e;

  typedef enum logic [3:0] {
    AM3_IMPL, AM3_IMM, AM3_REL, AM3_ZPG, AM3_ZPX, AM3_ZPY,
    AM3_ABS, AM3_ABX, AM3_ABY, AM3_IZX, AM3_IZY, AM3_ILL
  } am3_mode_e;

  typedef enum logic [1:0] {IDX_NONE, IDX_X, IDX_Y} index_sel_e;

  typedef enum logic [1:0] {IND_NONE, IND_PRE, IND_POST} indirect_e;

  typedef struct packed {
    logic       illegal;
    am3_mode_e  mode;
    logic [1:0] operand_bytes;
    index_sel_e index_sel;
    indirect_e  indirect;
    logic       zero_page;
  } mode_info_t;

endpackage

// File: rtl/fetch_mode_decode.sv
// Combinational opcode-to-addressing-mode decoder (cc/bbb split of the 6502 map).
module fetch_mode_decode
  import fetch_sequencer_pkg::*;
(
  input  logic [OPC_W-1:0] opcode,
  output mode_info_t       info
);

  logic [1:0] cc;
  logic [2:0] bbb;
  am3_mode_e  mode;

  assign cc  = opcode[1:0];
  assign bbb = opcode[4:2];

  always_comb begin
    mode = AM3_ILL;
    if (cc == 2'b01) begin
      case (bbb)
        3'd0:    mode = AM3_IZX;
        3'd1:    mode = AM3_ZPG;
        3'd2:    mode = AM3_IMM;
        3'd3:    mode = AM3_ABS;
        3'd4:    mode = AM3_IZY;
        3'd5:    mode = AM3_ZPX;
        3'd6:    mode = AM3_ABY;
        default: mode = AM3_ABX;
      endcase
    end else if (cc != 2'b11) begin
      // LDX/STX zero-page and LDX absolute index with Y instead of X
      case (bbb)
        3'd0:       mode = AM3_IMM;
        3'd1:       mode = AM3_ZPG;
        3'd2, 3'd6: mode = AM3_IMPL;
        3'd3:       mode = AM3_ABS;
        3'd4:       mode = AM3_REL;
        3'd5:       mode = (opcode == 8'h96 || opcode == 8'hB6) ? AM3_ZPY : AM3_ZPX;
        default:    mode = (opcode == 8'hBE) ? AM3_ABY : AM3_ABX;
      endcase
    end
  end

  always_comb begin
    info         = '0;
    info.mode    = mode;
    info.illegal = (mode == AM3_ILL);
    case (mode)
      AM3_IMM, AM3_REL: info.operand_bytes = 2'd1;
      AM3_ZPG: begin
        info.operand_bytes = 2'd1;
        info.zero_page     = 1'b1;
      end
      AM3_ZPX, AM3_ZPY: begin
        info.operand_bytes = 2'd1;
        info.zero_page     = 1'b1;
        info.index_sel     = (mode == AM3_ZPX) ? IDX_X : IDX_Y;
      end
      AM3_ABS: info.operand_bytes = 2'd2;
      AM3_ABX, AM3_ABY: begin
        info.operand_bytes = 2'd2;
        info.index_sel     = (mode == AM3_ABX) ? IDX_X : IDX_Y;
      end
      AM3_IZX, AM3_IZY: begin
        info.operand_bytes = 2'd1;
        info.zero_page     = 1'b1;
        info.index_sel     = (mode == AM3_IZX) ? IDX_X : IDX_Y;
        info.indirect      = (mode == AM3_IZX) ? IND_PRE : IND_POST;
      end
      default: info.operand_bytes = 2'd0;
    endcase
  end

endmodule

// File: rtl/fetch_sequencer.sv
// 6502 instruction fetch / effective-address sequencer: owns the PC, reads opcode,
// operand and pointer bytes, then holds the instruction for the decoder until done.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH = 16,
  parameter int unsigned           REG_WIDTH  = 8,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(16'h0600)
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_rd,
  input  logic [REG_WIDTH-1:0]  mem_data,
  input  logic [REG_WIDTH-1:0]  x_in,
  input  logic [REG_WIDTH-1:0]  y_in,
  output logic [REG_WIDTH-1:0]  instruction,
  output logic [ADDR_WIDTH-1:0] operand_addr,
  output logic                  instruction_ready,
  input  logic                  instruction_done,
  input  logic                  pc_load,
  input  logic [ADDR_WIDTH-1:0] pc_load_value,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic                  halt
);

  fs_state_e              state, state_next;
  mode_info_t             info;
  logic [OPC_W-1:0]       dec_opcode, data_byte, idx, zp_sum, lo_byte, ptr, ptr_inc;
  logic [OPC_W-1:0]       lo_next, ptr_next;
  logic                   second, second_next, exec_first, exec_first_next;
  logic [ADDR_WIDTH-1:0]  pc_next, mem_addr_next, opaddr_next, abs_sum, ind_addr, pc_target;
  logic [REG_WIDTH-1:0]   instr_next;
  logic                   mem_rd_next, ready_next, halt_next;

  // The opcode is only in mem_data during OP_CAP; afterwards it lives in instruction.
  assign data_byte  = mem_data[OPC_W-1:0];
  assign dec_opcode = (state == FS_OP_CAP) ? data_byte : instruction[OPC_W-1:0];

  fetch_mode_decode u_decode (
    .opcode (dec_opcode),
    .info   (info)
  );

  always_comb begin
    case (info.index_sel)
      IDX_X:   idx = x_in[OPC_W-1:0];
      IDX_Y:   idx = y_in[OPC_W-1:0];
      default: idx = '0;
    endcase
  end

  // Zero-page arithmetic stays 8 bits wide so page wrap is automatic.
  assign zp_sum    = data_byte + ((info.indirect == IND_POST) ? '0 : idx);
  assign ptr_inc   = ptr + 8'd1;
  assign abs_sum   = ADDR_WIDTH'({data_byte, lo_byte}) + ADDR_WIDTH'(idx);
  assign ind_addr  = ADDR_WIDTH'({data_byte, lo_byte}) +
                     ((info.indirect == IND_POST) ? ADDR_WIDTH'(idx) : '0);
  assign pc_target = pc_load ? pc_load_value : pc;

  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= FS_FETCH;
      pc                <= RESET_PC;
      mem_addr          <= RESET_PC;
      mem_rd            <= 1'b0;
      instruction       <= '0;
      operand_addr      <= '0;
      instruction_ready <= 1'b0;
      halt              <= 1'b0;
      lo_byte           <= '0;
      ptr               <= '0;
      second            <= 1'b0;
      exec_first        <= 1'b0;
    end else begin
      state             <= state_next;
      pc                <= pc_next;
      mem_addr          <= mem_addr_next;
      mem_rd            <= mem_rd_next;
      instruction       <= instr_next;
      operand_addr      <= opaddr_next;
      instruction_ready <= ready_next;
      halt              <= halt_next;
      lo_byte           <= lo_next;
      ptr               <= ptr_next;
      second            <= second_next;
      exec_first        <= exec_first_next;
    end
  end

  // Outputs are computed for the state being entered, then registered.
  always_comb begin
    state_next      = state;
    pc_next         = pc;
    mem_addr_next   = mem_addr;
    mem_rd_next     = 1'b0;
    instr_next      = instruction;
    opaddr_next     = operand_addr;
    ready_next      = 1'b0;
    halt_next       = 1'b0;
    lo_next         = lo_byte;
    ptr_next        = ptr;
    second_next     = second;
    exec_first_next = 1'b0;

    case (state)
      FS_FETCH: begin
        // Straight out of reset the read strobe is not yet up; raise it first.
        if (mem_rd) begin
          state_next = FS_OP_CAP;
        end else begin
          mem_rd_next   = 1'b1;
          mem_addr_next = pc;
        end
      end
      FS_OP_CAP: begin
        instr_next = mem_data;
        pc_next    = pc + ADDR_WIDTH'(1);
        if (info.illegal) begin
          state_next = FS_HALT;
          halt_next  = 1'b1;
        end else if (info.mode == AM3_IMPL) begin
          state_next      = FS_EXEC;
          ready_next      = 1'b1;
          exec_first_next = 1'b1;
        end else if (info.mode == AM3_IMM || info.mode == AM3_REL) begin
          opaddr_next     = pc + ADDR_WIDTH'(1);
          pc_next         = pc + ADDR_WIDTH'(2);
          state_next      = FS_EXEC;
          ready_next      = 1'b1;
          exec_first_next = 1'b1;
        end else begin
          state_next    = FS_OPR_REQ;
          mem_rd_next   = 1'b1;
          mem_addr_next = pc + ADDR_WIDTH'(1);
          second_next   = 1'b0;
        end
      end
      FS_OPR_REQ: begin
        state_next = FS_OPR_CAP;
        pc_next    = pc + ADDR_WIDTH'(1);
      end
      FS_OPR_CAP: begin
        if (info.operand_bytes == 2'd2 && !second) begin
          lo_next       = data_byte;
          second_next   = 1'b1;
          state_next    = FS_OPR_REQ;
          mem_rd_next   = 1'b1;
          mem_addr_next = pc;
        end else if (info.indirect != IND_NONE) begin
          ptr_next      = zp_sum;
          second_next   = 1'b0;
          state_next    = FS_PTR_REQ;
          mem_rd_next   = 1'b1;
          mem_addr_next = ADDR_WIDTH'(zp_sum);
        end else begin
          opaddr_next     = info.zero_page ? ADDR_WIDTH'(zp_sum) : abs_sum;
          state_next      = FS_EXEC;
          ready_next      = 1'b1;
          exec_first_next = 1'b1;
        end
      end
      FS_PTR_REQ: state_next = FS_PTR_CAP;
      FS_PTR_CAP: begin
        if (!second) begin
          lo_next       = data_byte;
          second_next   = 1'b1;
          state_next    = FS_PTR_REQ;
          mem_rd_next   = 1'b1;
          mem_addr_next = ADDR_WIDTH'(ptr_inc);
        end else begin
          opaddr_next     = ind_addr;
          state_next      = FS_EXEC;
          ready_next      = 1'b1;
          exec_first_next = 1'b1;
        end
      end
      FS_EXEC: begin
        ready_next = 1'b1;
        // First EXEC cycle may still see the previous instruction's done level.
        if (!exec_first && instruction_done) begin
          state_next    = FS_FETCH;
          ready_next    = 1'b0;
          mem_rd_next   = 1'b1;
          pc_next       = pc_target;
          mem_addr_next = pc_target;
        end
      end
      default: halt_next = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: vector table through a scoreboard plus
// hand-written handshake, halt and mid-instruction reset sequences.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic [7:0]  mem_data = '0;
  logic [7:0]  x_in, y_in;
  logic [7:0]  instruction;
  logic [15:0] operand_addr;
  logic        instruction_ready;
  logic        instruction_done;
  logic        pc_load;
  logic [15:0] pc_load_value;
  logic [15:0] pc;
  logic        halt;

  logic [7:0]  mem [0:65535];
  int          checks = 0;
  int          failures = 0;

  typedef struct {
    string       name;
    logic [7:0]  b0, b1, b2, x, y;
    int          nopr;
    logic        ind;
    logic [15:0] pa0, pa1;
    logic [7:0]  pv0, pv1;
    int          exp_cycle;
    logic [15:0] exp_addr;
    logic        chk_addr;
    logic [15:0] exp_pc;
  } vec_t;

  typedef struct {
    int          cycle;
    logic [7:0]  instr;
    logic [15:0] addr;
    logic        chk_addr;
    logic [15:0] pc;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] rd_q[$];
  vec_t        vecs[16];

  always #5 clk = ~clk;

  // One-cycle read latency memory
  always @(posedge clk) if (mem_rd) mem_data <= mem[mem_addr];

  fetch_sequencer dut (
    .clk               (clk),
    .reset             (reset),
    .mem_addr          (mem_addr),
    .mem_rd            (mem_rd),
    .mem_data          (mem_data),
    .x_in              (x_in),
    .y_in              (y_in),
    .instruction       (instruction),
    .operand_addr      (operand_addr),
    .instruction_ready (instruction_ready),
    .instruction_done  (instruction_done),
    .pc_load           (pc_load),
    .pc_load_value     (pc_load_value),
    .pc                (pc),
    .halt              (halt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " pc"}, pc, 16'h0600);
    chk({tag, " mem_addr"}, mem_addr, 16'h0600);
    chk({tag, " mem_rd"}, mem_rd, 0);
    chk({tag, " instruction"}, instruction, 8'h00);
    chk({tag, " operand_addr"}, operand_addr, 16'h0000);
    chk({tag, " ready"}, instruction_ready, 0);
    chk({tag, " halt"}, halt, 0);
  endtask

  // Leaves the bench at a negedge with reset low; the next negedge is cycle 0.
  task automatic apply_reset(input bit chk_vals, input string tag);
    reset            = 1'b1;
    instruction_done = 1'b0;
    pc_load          = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    if (chk_vals) chk_reset_vals(tag);
    reset = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    exp_t e;
    bit   got;
    mem[16'h0600] = v.b0;
    mem[16'h0601] = v.b1;
    mem[16'h0602] = v.b2;
    if (v.ind) begin
      mem[v.pa0] = v.pv0;
      mem[v.pa1] = v.pv1;
    end
    x_in = v.x;
    y_in = v.y;
    rd_q.push_back(16'h0600);
    for (int i = 0; i < v.nopr; i++) rd_q.push_back(16'h0601 + 16'(i));
    if (v.ind) begin
      rd_q.push_back(v.pa0);
      rd_q.push_back(v.pa1);
    end
    e = '{v.exp_cycle, v.b0, v.exp_addr, v.chk_addr, v.exp_pc};
    exp_q.push_back(e);
    apply_reset(1'b0, "");
    got = 1'b0;
    for (int cyc = 0; cyc < 20 && !got; cyc++) begin
      @(negedge clk);
      if (mem_rd) begin
        if (rd_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL %s extra read: got %h expected none", v.name, mem_addr);
        end else begin
          chk({v.name, " read addr"}, mem_addr, rd_q.pop_front());
        end
      end
      if (instruction_ready && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk({v.name, " ready cycle"}, cyc, e.cycle);
        chk({v.name, " instruction"}, instruction, e.instr);
        chk({v.name, " pc"}, pc, e.pc);
        if (e.chk_addr) chk({v.name, " operand_addr"}, operand_addr, e.addr);
        got = 1'b1;
      end
    end
    chk({v.name, " ready seen"}, got, 1);
    chk({v.name, " reads left"}, rd_q.size(), 0);
    rd_q.delete();
    exp_q.delete();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int reads, readies;
    reset = 1'b1; x_in = '0; y_in = '0;
    instruction_done = 1'b0; pc_load = 1'b0; pc_load_value = '0;

    //          name        b0     b1     b2     x      y      n  ind pa0       pa1       pv0    pv1    cyc addr      chk   pc
    vecs[0]  = '{"impl EA",  8'hEA, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 16'h0000, 16'h0000, 8'h00, 8'h00, 2, 16'h0000, 1'b0, 16'h0601};
    vecs[1]  = '{"impl 0A",  8'h0A, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 16'h0000, 16'h0000, 8'h00, 8'h00, 2, 16'h0000, 1'b0, 16'h0601};
    vecs[2]  = '{"imm A9",   8'hA9, 8'h55, 8'h00, 8'h00, 8'h00, 0, 0, 16'h0000, 16'h0000, 8'h00, 8'h00, 2, 16'h0601, 1'b1, 16'h0602};
    vecs[3]  = '{"rel F0",   8'hF0, 8'h10, 8'h00, 8'h00, 8'h00, 0, 0, 16'h0000, 16'h0000, 8'h00, 8'h00, 2, 16'h0601, 1'b1, 16'h0602};
    vecs[4]  = '{"zpg A5",   8'hA5, 8'h80, 8'h00, 8'h00, 8'h00, 1, 0, 16'h0000, 16'h0000, 8'h00, 8'h00, 4, 16'h0080, 1'b1, 16'h0602};
    vecs[5]  = '{"zpx B5",   8'hB5, 8'hF0, 8'h00, 8'h20, 8'h00, 1, 0, 16'h0000, 16'h0000, 8'h00, 8'h00, 4, 16'h0010, 1'b1, 16'h0602};
    vecs[6]  = '{"zpy B6",   8'hB6, 8'hF0, 8'h00, 8'h00, 8'h20, 1, 0, 16'h0000, 16'h0000, 8'h00, 8'h00, 4, 16'h0010, 1'b1, 16'h0602};
    vecs[7]  = '{"abs AD",   8'hAD, 8'h34, 8'h12, 8'h00, 8'h00, 2, 0, 16'h0000, 16'h0000, 8'h00, 8'h00, 6, 16'h1234, 1'b1, 16'h0603};
    vecs[8]  = '{"abx BD",   8'hBD, 8'hF0, 8'h12, 8'h20, 8'h00, 2, 0, 16'h0000, 16'h0000, 8'h00, 8'h00, 6, 16'h1310, 1'b1, 16'h0603};
    vecs[9]  = '{"aby BE",   8'hBE, 8'hFF, 8'hFF, 8'h00, 8'h02, 2, 0, 16'h0000, 16'h0000, 8'h00, 8'h00, 6, 16'h0001, 1'b1, 16'h0603};
    vecs[10] = '{"aby B9",   8'hB9, 8'h00, 8'h20, 8'h00, 8'h05, 2, 0, 16'h0000, 16'h0000, 8'h00, 8'h00, 6, 16'h2005, 1'b1, 16'h0603};
    vecs[11] = '{"abs AE",   8'hAE, 8'h00, 8'h01, 8'h00, 8'h00, 2, 0, 16'h0000, 16'h0000, 8'h00, 8'h00, 6, 16'h0100, 1'b1, 16'h0603};
    vecs[12] = '{"izx A1",   8'hA1, 8'h40, 8'h00, 8'h05, 8'h00, 1, 1, 16'h0045, 16'h0046, 8'h78, 8'h56, 8, 16'h5678, 1'b1, 16'h0602};
    vecs[13] = '{"izx wrap", 8'hA1, 8'hFE, 8'h00, 8'h01, 8'h00, 1, 1, 16'h00FF, 16'h0000, 8'hCD, 8'hAB, 8, 16'hABCD, 1'b1, 16'h0602};
    vecs[14] = '{"izy wrap", 8'hB1, 8'hFF, 8'h00, 8'h00, 8'h03, 1, 1, 16'h00FF, 16'h0000, 8'hFE, 8'hFF, 8, 16'h0001, 1'b1, 16'h0602};
    vecs[15] = '{"izy B1",   8'hB1, 8'h20, 8'h00, 8'h00, 8'h10, 1, 1, 16'h0020, 16'h0021, 8'hF8, 8'h30, 8, 16'h3108, 1'b1, 16'h0602};

    apply_reset(1'b1, "por");

    foreach (vecs[i]) run_vec(vecs[i]);

    // Decoder handshake: early done ignored, late done with pc_load redirects.
    mem[16'h0600] = 8'hEA;
    mem[16'h8000] = 8'hA9;
    mem[16'h8001] = 8'h11;
    apply_reset(1'b0, "");
    step(3);
    chk("hs ready c2", instruction_ready, 1);
    instruction_done = 1'b1;
    step(1);
    chk("hs early done ignored", instruction_ready, 1);
    instruction_done = 1'b0;
    pc_load = 1'b1;
    pc_load_value = 16'h8000;
    step(1);
    chk("hs stray pc_load ignored", pc, 16'h0601);
    chk("hs ready c4", instruction_ready, 1);
    instruction_done = 1'b1;
    step(1);
    instruction_done = 1'b0;
    pc_load = 1'b0;
    chk("hs ready drop", instruction_ready, 0);
    chk("hs refetch rd", mem_rd, 1);
    chk("hs refetch addr", mem_addr, 16'h8000);
    chk("hs pc loaded", pc, 16'h8000);
    step(1);
    chk("hs ready low 2nd", instruction_ready, 0);
    step(1);
    chk("hs ready again", instruction_ready, 1);
    chk("hs instr A9", instruction, 8'hA9);
    chk("hs imm addr", operand_addr, 16'h8001);
    chk("hs pc after imm", pc, 16'h8002);

    // Illegal opcode traps and stops reading.
    mem[16'h0600] = 8'h03;
    apply_reset(1'b0, "");
    reads = 0;
    readies = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (mem_rd) reads++;
      if (instruction_ready) readies++;
      if (c == 1) chk("halt low c1", halt, 0);
      if (c == 2) chk("halt high c2", halt, 1);
    end
    chk("halt read count", reads, 1);
    chk("halt no ready", readies, 0);
    chk("halt held", halt, 1);

    // Reset during an absolute operand read.
    mem[16'h0600] = 8'hAD;
    mem[16'h0601] = 8'h34;
    mem[16'h0602] = 8'h12;
    apply_reset(1'b0, "");
    step(3);
    chk("mid opr rd", mem_rd, 1);
    chk("mid opr addr", mem_addr, 16'h0601);
    reset = 1'b1;
    step(1);
    chk_reset_vals("mid reset");
    reset = 1'b0;
    step(1);
    chk("mid restart rd", mem_rd, 1);
    chk("mid restart addr", mem_addr, 16'h0600);
    step(6);
    chk("mid restart ready", instruction_ready, 1);
    chk("mid restart opaddr", operand_addr, 16'h1234);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
